// File: rtl/subbyte_seq_if.sv
// ---------------------------------------------------------------------------
// subbyte_seq_if -- handshake bundle for the byte-substitution sequencer.
//   in_valid  : upstream has a 128-bit state to substitute
//   in_ready  : sequencer can accept a new state
//   in_data   : state to substitute, byte 0 = bits [127:120]
//   in_inv    : 0 = forward S-box, 1 = inverse S-box
//   out_valid : substituted state is available
//   out_ready : downstream accepts the result
//   out_data  : substituted state, same byte order as in_data
// master = producer/consumer side, slave = the sequencer itself.
// ---------------------------------------------------------------------------
interface subbyte_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_inv;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (
      output in_valid, in_data, in_inv, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_inv, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/subbyte_seq.sv
// ---------------------------------------------------------------------------
// subbyte_seq -- iterative AES SubBytes / InvSubBytes over a 128-bit state.
// A captured state is rewritten LANES bytes per cycle, in 16/LANES cycles,
// then presented until the consumer takes it.
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   bus : subbyte_seq_if.slave (in_valid/in_ready/in_data/in_inv,
//         out_valid/out_ready/out_data)
// Parameter LANES (1, 2, 4, 8, 16): bytes substituted per cycle.
// ---------------------------------------------------------------------------
module subbyte_seq #(
   parameter int LANES = 4
) (
   input logic          clk,
   input logic          rst,
   subbyte_seq_if.slave bus
);

   localparam int GROUPS = 16 / LANES;
   localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] grp;
   logic [127:0]  data_q;
   logic          inv_q;
   logic [127:0]  data_sub;

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse and conveniently maps 00 to 00,
   // which is exactly what the S-box definition needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = a;
      for (int i = 1; i < 8; i++) begin   // 254 = 8'b1111_1110
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
      return inv ? gf_inv(affine_inv(b)) : affine_fwd(gf_inv(b));
   endfunction

   // Substituted copy of the register: only the current group's lanes change.
   always_comb begin
      // NOTE: default the whole vector first so unselected bytes pass through
      // and no latch is inferred for them.
      data_sub = data_q;
      for (int l = 0; l < LANES; l++) begin
         int lo;
         lo = 120 - 8 * (int'(grp) * LANES + l);
         data_sub[lo +: 8] = sub_byte(data_q[lo +: 8], inv_q);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         grp    <= '0;
         // NOTE: the 128-bit data register is reset on purpose: out_data is
         // driven straight from it and must read zero during and after reset.
         data_q <= '0;
         inv_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  data_q <= bus.in_data;
                  inv_q  <= bus.in_inv;
                  grp    <= '0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               data_q <= data_sub;
               if (grp == LAST) begin
                  grp   <= '0;
                  state <= DONE;
               end else begin
                  grp <= grp + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_data  = data_q;

endmodule

// File: tb/tb_subbyte_seq.sv
// ---------------------------------------------------------------------------
// tb_subbyte_seq -- scoreboard bench for subbyte_seq.
// A LANES=4 instance runs directed vectors (known-answer, all-00/FF/16,
// backpressure, mode flip, reset mid-operation). Five further instances
// (LANES 1..16) run random blocks against a table model built here by the
// generator method. Drivers push expected results into queues; negedge
// monitors pop and compare whenever a result is presented.
// ---------------------------------------------------------------------------
module tb_subbyte_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] data;
      int unsigned  acc;
   } exp_t;

   logic [7:0] sbox  [256];
   logic [7:0] isbox [256];
   logic       sweep_go = 1'b0;
   int         sweep_done_cnt = 0;

   localparam logic [127:0] V_PT   = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] V_SUB  = 128'h63cab7040953d051cd60e0e7ba70e18c;
   localparam logic [127:0] ALL_00 = {16{8'h00}};
   localparam logic [127:0] ALL_63 = {16{8'h63}};
   localparam logic [127:0] ALL_FF = {16{8'hff}};
   localparam logic [127:0] ALL_16 = {16{8'h16}};
   localparam logic [127:0] ALL_7D = {16{8'h7d}};

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // Walk p over all nonzero elements (times 3) with q tracking 1/p.
   task automatic build_model();
      logic [7:0] p, q;
      p = 8'h01;
      q = 8'h01;
      repeat (255) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'b0000};
         if (q[7]) q = q ^ 8'h09;
         sbox[p] = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4) ^ 8'h63;
      end
      sbox[0] = 8'h63;
      for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
   endtask

   function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      logic [7:0]   b;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         b = d[127 - 8 * i -: 8];
         r[127 - 8 * i -: 8] = inv ? isbox[b] : sbox[b];
      end
      return r;
   endfunction

   // ---------------- directed instance (LANES = 4) ----------------
   subbyte_seq_if bus ();
   subbyte_seq #(.LANES(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t q_main[$];
   logic prev_valid = 1'b0;

   always @(negedge clk) begin
      if (bus.out_valid) begin
         check("main_in_ready_low_in_done", 128'(bus.in_ready), 128'd0);
         if (q_main.size() == 0) begin
            total++;
            bad++;
            $display("FAIL main_unexpected_output: got %h expected no output", bus.out_data);
         end else begin
            if (!prev_valid) check("main_latency", 128'(cyc), 128'(q_main[0].acc + 4));
            check("main_data", bus.out_data, q_main[0].data);
            if (bus.out_ready) void'(q_main.pop_front());
         end
      end
      prev_valid = bus.out_valid;
   end

   task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp,
                       output int waited);
      exp_t e;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_inv   = inv;
      waited = 0;
      @(negedge clk);
      while (!bus.in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         total++;
         bad++;
         $display("FAIL main_accept_timeout: got in_ready=0 expected 1 within 200 cycles");
      end else begin
         e.data = exp;
         e.acc  = cyc + 1;
         q_main.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q_main.size() != 0 || bus.out_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("main_drain", 128'(q_main.size()), 128'd0);
   endtask

   // ---------------- random sweep instances ----------------
   for (genvar gi = 0; gi < 5; gi++) begin : g_sweep
      localparam int LN = 1 << gi;
      localparam int GR = 16 / LN;

      subbyte_seq_if sbus ();
      subbyte_seq #(.LANES(LN)) u_dut (.clk(clk), .rst(rst), .bus(sbus));

      exp_t q[$];
      logic pv = 1'b0;

      always @(negedge clk) begin
         if (sbus.out_valid) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sweep%0d_unexpected_output: got %h expected no output", LN, sbus.out_data);
            end else begin
               if (!pv) check($sformatf("sweep%0d_latency", LN), 128'(cyc), 128'(q[0].acc + GR));
               if (sbus.out_ready) begin
                  check($sformatf("sweep%0d_data", LN), sbus.out_data, q[0].data);
                  void'(q.pop_front());
               end
            end
         end
         pv = sbus.out_valid;
      end

      initial begin
         logic [127:0] d;
         exp_t         e;
         int           n;
         sbus.in_valid  = 1'b0;
         sbus.in_data   = '0;
         sbus.in_inv    = 1'b0;
         sbus.out_ready = 1'b1;
         wait (sweep_go);
         for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 20; k++) begin
               d = {$urandom, $urandom, $urandom, $urandom};
               @(posedge clk);
               #1;
               sbus.in_valid = 1'b1;
               sbus.in_data  = d;
               sbus.in_inv   = (m == 1);
               n = 0;
               @(negedge clk);
               while (!sbus.in_ready && n < 100) begin
                  n++;
                  @(negedge clk);
               end
               if (!sbus.in_ready) begin
                  total++;
                  bad++;
                  $display("FAIL sweep%0d_accept_timeout: got in_ready=0 expected 1", LN);
               end else begin
                  e.data = model(d, m == 1);
                  e.acc  = cyc + 1;
                  q.push_back(e);
               end
               @(posedge clk);
               #1;
               sbus.in_valid = 1'b0;
            end
         end
         n = 0;
         while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
         end
         check($sformatf("sweep%0d_drain", LN), 128'(q.size()), 128'd0);
         sweep_done_cnt++;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int w;
      int n;
      build_model();
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_inv    = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready",  128'(bus.in_ready),  128'd1);
      check("reset_out_valid", 128'(bus.out_valid), 128'd0);
      check("reset_out_data",  bus.out_data,        128'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Known answer, accepted on the first edge after reset release.
      send(V_PT, 1'b0, V_SUB, w);
      check("first_accept_wait", 128'(w), 128'd0);
      send(V_SUB,  1'b1, V_PT,   w);
      send(ALL_00, 1'b0, ALL_63, w);
      send(ALL_FF, 1'b0, ALL_16, w);
      send(ALL_16, 1'b1, ALL_FF, w);
      drain();

      // Backpressure: result held, new block refused while stalled.
      bus.out_ready = 1'b0;
      send(V_PT, 1'b0, V_SUB, w);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("bp_valid_rise", 128'(bus.out_valid), 128'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = ALL_FF;
      bus.in_inv   = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("bp_in_ready_held_low", 128'(bus.in_ready), 128'd0);
      check("bp_data_held", bus.out_data, V_SUB);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_idle_after_handshake", 128'(bus.in_ready), 128'd1);
      send(ALL_FF, 1'b1, ALL_7D, w);
      check("bp_second_accept_wait", 128'(w), 128'd0);
      drain();

      // Mode/data flip right after acceptance must not affect the block.
      send(V_PT, 1'b0, V_SUB, w);
      bus.in_inv  = 1'b1;
      bus.in_data = {16{8'ha5}};
      drain();

      // Reset during the second BUSY cycle discards the block.
      send(V_PT, 1'b0, V_SUB, w);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
      check("midrst_out_data",  bus.out_data,        128'd0);
      check("midrst_in_ready",  128'(bus.in_ready),  128'd1);
      q_main.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(V_SUB, 1'b1, V_PT, w);
      check("midrst_next_accept_wait", 128'(w), 128'd0);
      drain();

      // Random sweep across all lane counts.
      sweep_go = 1'b1;
      n = 0;
      while (sweep_done_cnt < 5 && n < 20000) begin
         @(posedge clk);
         n++;
      end
      check("sweep_finished", 128'(sweep_done_cnt), 128'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/subbyte_seq.md
SUBBYTE_SEQ -- requirements
Module: subbyte_seq

Interface
REQ-001 SHALL have parameter LANES, default 4, giving bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, upstream block valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a new 128-bit state.
REQ-006 SHALL have port in_data, input, 128, state to substitute; byte 0 = bits [127:120].
REQ-007 SHALL have port in_inv, input, 1, 0 = SubBytes (forward S-box), 1 = InvSubBytes (inverse S-box).
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-010 SHALL have port out_data, output, 128, substituted state, same byte order as in_data.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 Input handshake (in_valid & in_ready at a rising edge) SHALL capture in_data into an internal 128-bit register, latch in_inv, clear group counter, enter BUSY.
REQ-013 in_inv and in_data changes after the accepting edge SHALL have no effect on the block in flight.
REQ-014 Each BUSY cycle SHALL replace bytes [g*LANES .. g*LANES+LANES-1] of the register (g = counter) with S(b) or InvS(b) per latched mode, then increment counter.
REQ-015 S and InvS SHALL be the FIPS-197 byte tables, bit-exact; the forward/inverse lookup per lane is combinational.
REQ-016 Counter width SHALL be clog2(16/LANES) (min 1 bit); after group 16/LANES-1 is processed, state SHALL move to DONE and counter SHALL wrap to 0.
REQ-017 Latency SHALL be exactly 16/LANES cycles: handshake at edge N gives out_valid high after edge N+16/LANES (LANES=4: N+4; LANES=16: N+1).
REQ-018 out_data SHALL be driven directly from the internal register; in DONE it SHALL hold stable while out_ready = 0 (no limit on stall duration).
REQ-019 Output handshake (out_valid & out_ready at an edge) SHALL return state to IDLE; in_ready rises the cycle after; no same-cycle re-accept.
REQ-020 in_valid asserted in BUSY or DONE SHALL be ignored (no capture, no state change); upstream must hold until in_ready.
REQ-021 out_ready in IDLE or BUSY SHALL have no effect.
REQ-022 in_data content including values 00 and FF SHALL not be special-cased; every byte value 00..FF maps per table.

Reset
REQ-023 rst high SHALL immediately force state IDLE, counter 0, internal register 0, latched mode 0; hence in_ready = 1, out_valid = 0, out_data = 0 while rst is high and after release.
REQ-024 rst asserted in BUSY or DONE SHALL discard the in-flight block; no partial result shall ever appear with out_valid = 1.
REQ-025 First handshake SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-026 LANES=4, in_inv=0, in_data=00102030405060708090a0b0c0d0e0f0 -> after 4 cycles out_data=63cab7040953d051cd60e0e7ba70e18c, out_valid=1.
REQ-027 in_inv=1, in_data=63cab7040953d051cd60e0e7ba70e18c -> out_data=00102030405060708090a0b0c0d0e0f0; all-00 forward -> all-63; all-FF forward -> all-16; all-16 inverse -> all-FF.
REQ-028 Backpressure: out_ready=0 for 10 cycles after out_valid, while in_valid=1 with different data -> out_data unchanged, in_ready=0, no second capture; out_ready=1 -> IDLE next cycle, then second block accepted.
REQ-029 Mode flip: toggle in_inv and in_data on the cycle after acceptance -> result matches mode/data latched at acceptance.
REQ-030 Reset mid-operation: assert rst at BUSY cycle 2 -> out_valid=0, out_data=0, in_ready=1 immediately; next block after release completes with correct value and 4-cycle latency.
REQ-031 Sweep LANES in {1,2,4,8,16} with 20 random blocks per mode against a table model -> zero mismatches, latency 16/LANES every block.
